// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronises and latches peripheral interrupts and drives external_int.
// Optional per-source level/edge selection register enabled by defining IRQ_TRIGGER_CFG_EN.
module irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               sel,
  input  logic               read,
  input  logic [3:0]         writeb,
  input  logic [2:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               external_int
);

  logic [NUM_SRC-1:0] sync_p0, sync_p1, prev_p2;
  logic [NUM_SRC-1:0] rise, pending, pending_nx, enable, enable_nx;
  logic [NUM_SRC-1:0] w1c_clr, claim_oh, claim_clr;
  logic [31:0]        wmask, rd_val;
  logic [4:0]         claim_id, in_service, in_service_nx;
  logic               busy, busy_nx;
  logic               rd_en, claim_rd, pend_wr, en_wr, comp_wr;
  logic               unused_bits;

  assign wmask    = {{8{writeb[3]}}, {8{writeb[2]}}, {8{writeb[1]}}, {8{writeb[0]}}};
  assign rd_en    = sel & read;
  assign claim_rd = rd_en & (addr == 3'd2);
  assign pend_wr  = sel & (|writeb) & (addr == 3'd0);
  assign en_wr    = sel & (|writeb) & (addr == 3'd1);
  assign comp_wr  = sel & writeb[0] & (addr == 3'd3);
  assign rise     = sync_p1 & ~prev_p2;
  assign w1c_clr  = pend_wr ? (wdata[NUM_SRC-1:0] & wmask[NUM_SRC-1:0]) : '0;
  assign unused_bits = ^{wdata[31:NUM_SRC], wmask[31:NUM_SRC]};

  // Lowest-numbered pending and enabled source wins the claim
  always_comb begin
    claim_id = '0;
    claim_oh = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i] & enable[i]) begin
        claim_id = 5'(i + 1);
        claim_oh = '0;
        claim_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    busy_nx       = busy;
    in_service_nx = in_service;
    claim_clr     = '0;
    if (claim_rd && !busy && (claim_id != 5'd0)) begin
      claim_clr     = claim_oh;
      busy_nx       = 1'b1;
      in_service_nx = claim_id;
    end else if (comp_wr && busy && (wdata[4:0] == in_service)) begin
      busy_nx       = 1'b0;
      in_service_nx = '0;
    end
  end

  assign enable_nx = en_wr ? ((enable & ~wmask[NUM_SRC-1:0]) | (wdata[NUM_SRC-1:0] & wmask[NUM_SRC-1:0]))
                           : enable;

`ifdef IRQ_TRIGGER_CFG_EN
  logic [NUM_SRC-1:0] trigger, trigger_nx;
  logic               trig_wr;

  assign trig_wr    = sel & (|writeb) & (addr == 3'd4);
  assign trigger_nx = trig_wr ? ((trigger & ~wmask[NUM_SRC-1:0]) | (wdata[NUM_SRC-1:0] & wmask[NUM_SRC-1:0]))
                              : trigger;
  // Level-mode sources mirror the synchronised line; clears have no effect on them
  assign pending_nx = ((((pending & ~(w1c_clr | claim_clr)) | rise)) & ~trigger) | (sync_p1 & trigger);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trigger <= '0;
    else        trigger <= trigger_nx;
  end
`else
  // A new rise in the same cycle as a clear keeps the bit set
  assign pending_nx = (pending & ~(w1c_clr | claim_clr)) | rise;
`endif

  always_comb begin
    rd_val = '0;
    case (addr)
      3'd0: rd_val[NUM_SRC-1:0] = pending;
      3'd1: rd_val[NUM_SRC-1:0] = enable;
      3'd2: rd_val[4:0]         = busy ? in_service : claim_id;
`ifdef IRQ_TRIGGER_CFG_EN
      3'd4: rd_val[NUM_SRC-1:0] = trigger;
`endif
      default: rd_val = '0;
    endcase
  end

  // Stage boundary: synchroniser, edge history and register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0      <= '0;
      sync_p1      <= '0;
      prev_p2      <= '0;
      pending      <= '0;
      enable       <= '0;
      busy         <= 1'b0;
      in_service   <= '0;
      rdata        <= '0;
      external_int <= 1'b0;
    end else begin
      sync_p0      <= irq_in;
      sync_p1      <= sync_p0;
      prev_p2      <= sync_p1;
      pending      <= pending_nx;
      enable       <= enable_nx;
      busy         <= busy_nx;
      in_service   <= in_service_nx;
      external_int <= ~busy & (|(pending & enable));
      if (rd_en) rdata <= rd_val;
    end
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller; responder on the data-memory bus driven by the memory/branch stage (word address, byte write strobes, read strobe, 1-cycle registered read data).
- Collects peripheral interrupt lines, latches and prioritises them, and drives the core's external_int input.
- The claim/complete handshake through its registers lets the trap handler identify and retire each interrupt.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..31); source IDs are 1..NUM_SRC, and ID 0 means "none".

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- irq_in  in  NUM_SRC  raw peripheral interrupt lines, asynchronous to clk; bit i is source ID i+1
- sel  in  1  bus access targets this block (address decoded upstream)
- read  in  1  read strobe, qualified by sel
- writeb  in  4  byte-lane write strobes, qualified by sel
- addr  in  3  word address of the register
- wdata  in  32  write data, byte-lane aligned
- rdata  out  32  registered read data
- external_int  out  1  registered interrupt request to the core

Behaviour:
- Reset (asynchronous, rst_n=0): all state cleared, including synchronisers, edge history, pending, enable, busy and in-service ID; rdata=0; external_int=0.
- Input path: each irq_in bit passes a 2-flop synchroniser to give s[i]. An edge flop holds the previous s. rise[i] = s[i] & ~prev[i].
- Pending: pending[i] is set on rise[i]. It is cleared by W1C on PENDING or by a claim of ID i+1.
  - Set wins over a clear in the same cycle.
- Register map (word addresses; unused bits read 0; writes to RO or unmapped addresses are ignored):
  - 0 PENDING: RW1C, bits [NUM_SRC-1:0].
  - 1 ENABLE: RW, bits [NUM_SRC-1:0].
  - 2 CLAIM: RO, with a read side effect.
  - 3 COMPLETE: WO; a write carries the ID in wdata[4:0].
  - 4 TRIGGER: only with the optional feature.
- Byte lanes: writeb[k] gates wdata[8k+7:8k]. Lanes with writeb[k]=0 leave their bits unchanged; W1C applies only to strobed lanes.
- Read: sel&read at edge N loads rdata at edge N. The value is valid from N until the next read. rdata holds its value when there is no read.
- Claim (sel&read at addr 2):
  - busy=0: return ID = lowest index i with pending[i]&enable[i], as i+1, or 0 if none. If ID≠0, clear pending[i], set busy=1 and in_service=ID.
  - busy=1: return in_service, with no side effects.
- Complete (sel & writeb[0] at addr 3): if busy and wdata[4:0]==in_service, clear busy and set in_service=0. Otherwise ignore.
- external_int register <= ~busy & |(pending & enable).
  - It drops the cycle after a claim.
  - It may reassert the cycle after a complete.
- Latency: irq_in rises before edge 1 → pending set at edge 3 → external_int=1 at edge 4.
- Disabled sources still latch pending. Enabling a source that is already pending raises external_int one edge later.
- Simultaneous claim read and new rise on the same source: pending remains 1 (set wins).
- Simultaneous read and write (sel, read and writeb all asserted) is legal. The read returns the pre-write value; the write applies.

Optional Feature:
- Macro IRQ_TRIGGER_CFG_EN.
- Defined: adds register 4 TRIGGER (RW, reset 0). Bit i=0 selects rising-edge mode, as described above. Bit i=1 selects level mode:
  - pending[i] follows s[i] every cycle.
  - W1C and claim do not clear it.
  - Claim still sets busy.
- Undefined: register 4 is unmapped (reads 0, writes ignored) and all sources are rising-edge.

Test Plan:
- Reset mid-operation: NUM_SRC=8, source 3 pending, busy=1; pulse rst_n low → rdata=0, external_int=0; PENDING reads 0x00, CLAIM reads 0.
- Latency and claim: ENABLE=0x04; raise irq_in[2] before edge 1 → external_int=1 at edge 4; CLAIM read → rdata=3; external_int=0 the next edge; PENDING reads 0x00.
- Priority and busy: ENABLE=0xFF; irq_in[5] and irq_in[1] rise together → CLAIM=2; second CLAIM=2 (busy); COMPLETE wdata=6 ignored; COMPLETE wdata=2 → external_int=1; CLAIM=6.
- Byte-lane and W1C: write ENABLE wdata=0xFFFF, writeb=0b0010 → ENABLE reads 0x00; PENDING=0x81, write 0x01 with writeb=0b0001 → reads 0x80; a rise on the same bit in the W1C cycle leaves the bit set.
- Disabled source: ENABLE=0; rise irq_in[0] → external_int stays 0, PENDING=0x01; write ENABLE=0x01 → external_int=1 one edge later.
- IRQ_TRIGGER_CFG_EN: TRIGGER=0x01, hold irq_in[0]=1 → CLAIM=1, PENDING still 0x01; COMPLETE 1 → external_int reasserts; drop the line → PENDING=0x00 three edges later.
